// File: rtl/attn_value_engine_if.sv
// Command, SRAM and status bundle of the attention value engine.
// slave = engine view, master = command issuer / SRAM owner view.
interface attn_value_engine_if #(
  parameter int DATA_W = 8
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [15:0]       length;
  logic [15:0]       head_dim;
  logic [15:0]       prob_base;
  logic [15:0]       v_base;
  logic [15:0]       v_stride;
  logic [15:0]       dst_base;
  logic [4:0]        out_shift;
  logic              sram_rd_en;
  logic [15:0]       sram_rd_addr;
  logic [DATA_W-1:0] sram_rd_data;
  logic              sram_wr_en;
  logic [15:0]       sram_wr_addr;
  logic [DATA_W-1:0] sram_wr_data;
  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  cmd_valid, length, head_dim, prob_base, v_base, v_stride, dst_base, out_shift,
    input  sram_rd_data,
    output cmd_ready, sram_rd_en, sram_rd_addr, sram_wr_en, sram_wr_addr, sram_wr_data,
    output busy, done, err
  );

  modport master (
    output cmd_valid, length, head_dim, prob_base, v_base, v_stride, dst_base, out_shift,
    output sram_rd_data,
    input  cmd_ready, sram_rd_en, sram_rd_addr, sram_wr_en, sram_wr_addr, sram_wr_data,
    input  busy, done, err
  );
endinterface

// File: rtl/attn_value_engine.sv
// Attention context stage: out[d] = requant(sum_j p[j]*V[j][d]), one SRAM port each way.
// Optional macro ATTNV_SKIP_ZERO_EN skips V reads for zero probabilities.
//
// state    | meaning
// S_IDLE   | ready for a command
// S_LD_RD  | read p[j] from SRAM
// S_LD_LAT | capture p[j] into the local buffer
// S_V_RD   | read V[j][d] (or skip a zero p[j] when enabled)
// S_V_MAC  | acc += p[j]*V[j][d]
// S_WR     | write requantized out[d]
// S_DONE   | done pulse (err with it on reject)
module attn_value_engine #(
  parameter int DATA_W  = 8,
  parameter int MAX_LEN = 64,
  parameter int ACC_W   = 32
) (
  input logic                clk,
  input logic                rst_n,
  attn_value_engine_if.slave bus
);

  localparam int IDX_W = $clog2(MAX_LEN);
  localparam logic signed [ACC_W:0] QMAX = (ACC_W+1)'((1 << (DATA_W-1)) - 1);
  localparam logic signed [ACC_W:0] QMIN = -(ACC_W+1)'(1 << (DATA_W-1));

  typedef enum logic [2:0] {
    S_IDLE, S_LD_RD, S_LD_LAT, S_V_RD, S_V_MAC, S_WR, S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [15:0]              j_q, j_d;
  logic [15:0]              d_q, d_d;
  logic [15:0]              row_ptr_q, row_ptr_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [15:0]              len_q, len_d;
  logic [15:0]              hd_q, hd_d;
  logic [15:0]              pbase_q, pbase_d;
  logic [15:0]              vbase_q, vbase_d;
  logic [15:0]              vstride_q, vstride_d;
  logic [15:0]              dbase_q, dbase_d;
  logic [4:0]               shift_q, shift_d;
  logic                     err_q, err_d;

  logic signed [DATA_W-1:0] pbuf_q [MAX_LEN];
  logic                     pbuf_we;
  logic signed [DATA_W-1:0] pbuf_cur;

  logic                     rd_en, wr_en;
  logic [15:0]              rd_addr, wr_addr;
  logic [DATA_W-1:0]        wr_data;

  logic                     cmd_bad;
  logic                     last_j;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W:0]    rq_rnd, rq_sum, rq_shr;
  logic [DATA_W-1:0]        rq_val;

  assign pbuf_cur = pbuf_q[j_q[IDX_W-1:0]];
  assign last_j   = (j_q == len_q - 16'd1);
  assign cmd_bad  = (bus.length == 16'd0) || (bus.head_dim == 16'd0) ||
                    (bus.length > 16'(MAX_LEN));

  assign prod     = pbuf_cur * $signed(bus.sram_rd_data);
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

  // Round half up, then arithmetic shift; one extra bit keeps the rounding add from overflowing.
  always_comb begin
    rq_rnd = '0;
    if (shift_q != 5'd0) rq_rnd = (ACC_W+1)'(1) << (shift_q - 5'd1);
    rq_sum = {acc_q[ACC_W-1], acc_q} + rq_rnd;
    rq_shr = rq_sum >>> shift_q;
    if (rq_shr > QMAX)      rq_val = QMAX[DATA_W-1:0];
    else if (rq_shr < QMIN) rq_val = QMIN[DATA_W-1:0];
    else                    rq_val = rq_shr[DATA_W-1:0];
  end

  always_comb begin
    state_d   = state_q;
    j_d       = j_q;
    d_d       = d_q;
    row_ptr_d = row_ptr_q;
    acc_d     = acc_q;
    len_d     = len_q;
    hd_d      = hd_q;
    pbase_d   = pbase_q;
    vbase_d   = vbase_q;
    vstride_d = vstride_q;
    dbase_d   = dbase_q;
    shift_d   = shift_q;
    err_d     = err_q;
    pbuf_we   = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          len_d     = bus.length;
          hd_d      = bus.head_dim;
          pbase_d   = bus.prob_base;
          vbase_d   = bus.v_base;
          vstride_d = bus.v_stride;
          dbase_d   = bus.dst_base;
          shift_d   = bus.out_shift;
          j_d       = '0;
          d_d       = '0;
          row_ptr_d = '0;
          acc_d     = '0;
          err_d     = cmd_bad;
          state_d   = cmd_bad ? S_DONE : S_LD_RD;
        end
      end

      S_LD_RD: begin
        rd_en   = 1'b1;
        rd_addr = pbase_q + j_q;
        state_d = S_LD_LAT;
      end

      S_LD_LAT: begin
        pbuf_we = 1'b1;
        if (last_j) begin
          j_d       = '0;
          d_d       = '0;
          acc_d     = '0;
          row_ptr_d = vbase_q;
          state_d   = S_V_RD;
        end else begin
          j_d     = j_q + 16'd1;
          state_d = S_LD_RD;
        end
      end

      S_V_RD: begin
`ifdef ATTNV_SKIP_ZERO_EN
        // A zero weight contributes nothing, so step past it without touching SRAM.
        if (pbuf_cur == '0) begin
          if (last_j) begin
            state_d = S_WR;
          end else begin
            j_d       = j_q + 16'd1;
            row_ptr_d = row_ptr_q + vstride_q;
          end
        end else begin
          rd_en   = 1'b1;
          rd_addr = row_ptr_q + d_q;
          state_d = S_V_MAC;
        end
`else
        rd_en   = 1'b1;
        rd_addr = row_ptr_q + d_q;
        state_d = S_V_MAC;
`endif
      end

      S_V_MAC: begin
        acc_d = acc_q + prod_ext;
        if (last_j) begin
          state_d = S_WR;
        end else begin
          j_d       = j_q + 16'd1;
          row_ptr_d = row_ptr_q + vstride_q;
          state_d   = S_V_RD;
        end
      end

      S_WR: begin
        wr_en   = 1'b1;
        wr_addr = dbase_q + d_q;
        wr_data = rq_val;
        if (d_q == hd_q - 16'd1) begin
          state_d = S_DONE;
        end else begin
          d_d       = d_q + 16'd1;
          j_d       = '0;
          row_ptr_d = vbase_q;
          acc_d     = '0;
          state_d   = S_V_RD;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      j_q       <= '0;
      d_q       <= '0;
      row_ptr_q <= '0;
      acc_q     <= '0;
      len_q     <= '0;
      hd_q      <= '0;
      pbase_q   <= '0;
      vbase_q   <= '0;
      vstride_q <= '0;
      dbase_q   <= '0;
      shift_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      j_q       <= j_d;
      d_q       <= d_d;
      row_ptr_q <= row_ptr_d;
      acc_q     <= acc_d;
      len_q     <= len_d;
      hd_q      <= hd_d;
      pbase_q   <= pbase_d;
      vbase_q   <= vbase_d;
      vstride_q <= vstride_d;
      dbase_q   <= dbase_d;
      shift_q   <= shift_d;
      err_q     <= err_d;
    end
  end

  // Probability buffer holds no reset; its contents are rewritten before every use.
  always_ff @(posedge clk) begin
    if (pbuf_we) pbuf_q[j_q[IDX_W-1:0]] <= $signed(bus.sram_rd_data);
  end

  assign bus.cmd_ready    = (state_q == S_IDLE);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.done         = (state_q == S_DONE);
  assign bus.err          = (state_q == S_DONE) && err_q;
  assign bus.sram_rd_en   = rd_en;
  assign bus.sram_rd_addr = rd_addr;
  assign bus.sram_wr_en   = wr_en;
  assign bus.sram_wr_addr = wr_addr;
  assign bus.sram_wr_data = wr_data;

endmodule
